// File: rtl/switch_pkg.sv
// Shared constants and types for the switch debounce/toggle front end.
package switch_pkg;

    localparam int unsigned NUM_SW                 = 4;
    localparam int unsigned CLK_HZ                 = 12_000_000;
    localparam int unsigned DEFAULT_DEBOUNCE_LIMIT = 120000;

    typedef logic [NUM_SW-1:0] sw_vec_t;

    // Clock cycles spanning the given number of milliseconds at CLK_HZ.
    function automatic int unsigned debounce_cycles(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// One switch channel: SYNC_STAGES-flop synchronizer feeding a counter debounce
// filter; o_Rise/o_Fall are registered 1-cycle pulses on accepted transitions.
module debounce_filter
    import switch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Raw,
    output logic o_Stable,
    output logic o_Rise,
    output logic o_Fall
);

    localparam int unsigned         CNT_W   = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       count;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_q   <= '0;
            count    <= '0;
            o_Stable <= 1'b0;
            o_Rise   <= 1'b0;
            o_Fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_Raw};
            o_Rise <= 1'b0;
            o_Fall <= 1'b0;
            // Any cycle agreeing with the accepted level restarts the count.
            if (sync == o_Stable) begin
                count <= '0;
            end else if (count == CNT_MAX) begin
                o_Stable <= sync;
                o_Rise   <= sync;
                o_Fall   <= ~sync;
                count    <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_debounce_toggle.sv
// Four debounced switches, each toggling a registered LED on press.
// Define SWITCH_BOTH_EDGE_EN to also toggle on release (LED follows the switch).
module switch_debounce_toggle
    import switch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
    input  logic i_Switch_3,
    input  logic i_Switch_4,
    output logic o_LED_1,
    output logic o_LED_2,
    output logic o_LED_3,
    output logic o_LED_4
);

`ifdef SWITCH_BOTH_EDGE_EN
    localparam logic BOTH_EDGE = 1'b1;
`else
    localparam logic BOTH_EDGE = 1'b0;
`endif

    sw_vec_t raw;
    sw_vec_t rise;
    sw_vec_t fall;
    sw_vec_t unused_stable;
    sw_vec_t toggle;
    sw_vec_t led_q;

    assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    for (genvar ch = 0; ch < NUM_SW; ch++) begin : g_ch
        debounce_filter #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
            .SYNC_STAGES   (SYNC_STAGES)
        ) u_filter (
            .i_Clk   (i_Clk),
            .i_Rst_L (i_Rst_L),
            .i_Raw   (raw[ch]),
            .o_Stable(unused_stable[ch]),
            .o_Rise  (rise[ch]),
            .o_Fall  (fall[ch])
        );
    end

    always_comb begin
        toggle = rise | (fall & {NUM_SW{BOTH_EDGE}});
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            led_q <= '0;
        end else begin
            led_q <= led_q ^ toggle;
        end
    end

    assign o_LED_1 = led_q[0];
    assign o_LED_2 = led_q[1];
    assign o_LED_3 = led_q[2];
    assign o_LED_4 = led_q[3];

endmodule

// File: tb/tb_switch_debounce_toggle.sv
// Bench for switch_debounce_toggle (DEBOUNCE_LIMIT=8, SYNC_STAGES=2): directed
// table, hand sequences and random stimulus against a window-based model.
module tb_switch_debounce_toggle;

    localparam int unsigned LIMIT = 8;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned WIN   = SYNC + LIMIT;

`ifdef SWITCH_BOTH_EDGE_EN
    localparam bit BOTH = 1'b1;
`else
    localparam bit BOTH = 1'b0;
`endif

    typedef struct {
        logic [3:0]  sw;
        int unsigned cycles;
        logic [3:0]  exp_def;
        logic [3:0]  exp_both;
    } vec_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw    = 4'h0;
    logic       led1, led2, led3, led4;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Model: a channel accepts the opposite level once the last LIMIT samples
    // seen through the SYNC-cycle delay all differ from the accepted level.
    bit [WIN-1:0] hist [4];
    bit           m_stable [4];
    bit           m_pend [4];
    logic [3:0]   m_led;

    vec_t vecs[$];

    switch_debounce_toggle #(
        .DEBOUNCE_LIMIT(LIMIT),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .i_Clk     (clk),
        .i_Rst_L   (rst_n),
        .i_Switch_1(sw[0]),
        .i_Switch_2(sw[1]),
        .i_Switch_3(sw[2]),
        .i_Switch_4(sw[3]),
        .o_LED_1   (led1),
        .o_LED_2   (led2),
        .o_LED_3   (led3),
        .o_LED_4   (led4)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] led_now();
        return {led4, led3, led2, led1};
    endfunction

    function automatic void model_reset();
        for (int ch = 0; ch < 4; ch++) begin
            hist[ch]     = '0;
            m_stable[ch] = 1'b0;
            m_pend[ch]   = 1'b0;
        end
        m_led = 4'h0;
    endfunction

    function automatic void model_edge(input logic [3:0] raw);
        for (int ch = 0; ch < 4; ch++) begin
            bit all_new;
            if (m_pend[ch]) m_led[ch] = ~m_led[ch];
            m_pend[ch] = 1'b0;
            hist[ch] = {hist[ch][WIN-2:0], raw[ch]};
            all_new = 1'b1;
            for (int k = SYNC; k < WIN; k++)
                if (hist[ch][k] == m_stable[ch]) all_new = 1'b0;
            if (all_new) begin
                m_stable[ch] = ~m_stable[ch];
                m_pend[ch]   = m_stable[ch] | BOTH;
            end
        end
    endfunction

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: leds=%b expected=%b", name, $time, got, exp);
        end
    endtask

    task automatic tick(input logic [3:0] raw);
        sw = raw;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(raw);
        #1;
        check("model", led_now(), m_led);
    endtask

    task automatic run(input logic [3:0] raw, input int unsigned n);
        repeat (n) tick(raw);
    endtask

    function automatic void add(input logic [3:0] s, input int unsigned c,
                                input logic [3:0] d, input logic [3:0] b);
        vec_t v;
        v.sw = s; v.cycles = c; v.exp_def = d; v.exp_both = b;
        vecs.push_back(v);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  cur;
        int unsigned left [4];

        // clean press on switch 2, then release
        add(4'b0010, 10, 4'hF, 4'h0);
        add(4'b0010,  1, 4'hD, 4'h2);
        add(4'b0010, 29, 4'hD, 4'h2);
        add(4'b0000, 10, 4'hD, 4'h2);
        add(4'b0000,  1, 4'hD, 4'h0);
        add(4'b0000, 10, 4'hD, 4'h0);
        // bounce 1,0,1,1,0 on switch 1 then solid press
        add(4'b0001,  1, 4'hD, 4'h0);
        add(4'b0000,  1, 4'hD, 4'h0);
        add(4'b0001,  1, 4'hD, 4'h0);
        add(4'b0001,  1, 4'hD, 4'h0);
        add(4'b0000,  1, 4'hD, 4'h0);
        add(4'b0001, 10, 4'hD, 4'h0);
        add(4'b0001,  1, 4'hC, 4'h1);
        add(4'b0000, 20, 4'hC, 4'h0);
        // 7-cycle glitch rejected, 8-cycle pulse accepted on switch 3
        add(4'b0100,  7, 4'hC, 4'h0);
        add(4'b0000, 15, 4'hC, 4'h0);
        add(4'b0100,  8, 4'hC, 4'h0);
        add(4'b0000,  3, 4'h8, 4'h4);
        add(4'b0000, 12, 4'h8, 4'h0);
        // simultaneous presses on all channels
        add(4'b1111, 10, 4'h8, 4'h0);
        add(4'b1111,  1, 4'h7, 4'hF);
        add(4'b1111, 20, 4'h7, 4'hF);
        add(4'b0000, 10, 4'h7, 4'hF);
        add(4'b0000,  1, 4'h7, 4'h0);
        add(4'b0000, 20, 4'h7, 4'h0);
        add(4'b1111, 11, 4'h8, 4'hF);
        add(4'b0000, 11, 4'h8, 4'h0);
        add(4'b0000, 10, 4'h8, 4'h0);
        // switch 4 held: counter at 5 after these cycles
        add(4'b1000,  7, 4'h8, 4'h0);

        model_reset();
        sw    = 4'hF;
        rst_n = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("reset_hold", led_now(), 4'h0);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick(4'hF);
            check("reset_release", led_now(), (k == 11) ? 4'hF : 4'h0);
        end
        run(4'h0, 20);

        for (int i = 0; i < vecs.size(); i++) begin
            run(vecs[i].sw, vecs[i].cycles);
            check($sformatf("vec%0d", i), led_now(), BOTH ? vecs[i].exp_both : vecs[i].exp_def);
        end

        // async reset mid-count, no clock edge in between
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", led_now(), 4'h0);
        model_reset();
        run(4'b1000, 3);
        rst_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick(4'b1000);
            check("reset_repress", led_now(), (k == 11) ? 4'h8 : 4'h0);
        end
        run(4'h0, 20);

        cur = 4'h0;
        for (int ch = 0; ch < 4; ch++) left[ch] = $urandom_range(1, 12);
        for (int t = 0; t < 400; t++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (left[ch] == 0) begin
                    cur[ch]  = ~cur[ch];
                    left[ch] = $urandom_range(1, 12);
                end else begin
                    left[ch]--;
                end
            end
            if (t == 200) begin
                rst_n = 1'b0;
                model_reset();
            end
            if (t == 203) rst_n = 1'b1;
            tick(cur);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
